max_unit_scheduler: RTL and testbench

MAX_UNIT_SCHEDULER -- requirements
Module: max_unit_scheduler

---
 rtl/max_unit_pkg.sv | 15 +
 rtl/max_unit_scheduler_rr_arbiter.sv | 29 ++
 rtl/max_unit_scheduler.sv | 156 +++++++++++++++
 tb/tb_max_unit_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/max_unit_pkg.sv
// Shared types and default sizing for the max-unit request scheduler.
package max_unit_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_TIMEOUT_CYC = 255;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH,
    RESPOND
  } state_e;

endpackage

// File: rtl/max_unit_scheduler_rr_arbiter.sv
// Combinational round-robin pick: nearest requester after last_grant wins.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
    return IDX_W'(v % N_REQ);
  endfunction

  // Offsets walked from farthest to nearest so the nearest active requester
  // is the last assignment; offset N_REQ (last_grant itself) ranks lowest.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[wrap_idx(int'(last_grant) + k)]) begin
        grant_idx   = wrap_idx(int'(last_grant) + k);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/max_unit_scheduler.sv
// Shares one max unit among N_REQ requesters: round-robin grant, operand
// latch, start/done handshake with stale-done filtering and a wait timeout.
//
// state     | meaning
// IDLE      | no operation; grant on any request
// ISSUE     | one-cycle unit_start, timeout counter cleared
// WAIT_LOW  | wait for the previous operation's done to drop
// WAIT_HIGH | wait for done of this operation
// RESPOND   | one-cycle ack to the granted requester
module max_unit_scheduler
  import max_unit_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       resp_result,
  output logic                   resp_err,
  output logic                   busy,
  output logic                   unit_start,
  output logic [WIDTH-1:0]       unit_a,
  output logic [WIDTH-1:0]       unit_b,
  input  logic [WIDTH-1:0]       unit_result,
  input  logic                   unit_done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timed_out;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [WIDTH-1:0]   op_a [N_REQ];
  logic [WIDTH-1:0]   op_b [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_ops
    assign op_a[g] = req_a[g*WIDTH +: WIDTH];
    assign op_b[g] = req_b[g*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign cnt_inc   = cnt_q + 1'b1;
  assign timed_out = (cnt_inc == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d      = arb_idx;
          last_grant_d = arb_idx;
          a_d          = op_a[arb_idx];
          b_d          = op_b[arb_idx];
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        cnt_d = cnt_inc;
        if (timed_out) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESPOND;
        end else if (!unit_done) begin
          state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        cnt_d = cnt_inc;
        // A real completion on the last allowed cycle beats the timeout.
        if (unit_done) begin
          result_d = unit_result;
          err_d    = 1'b0;
          state_d  = RESPOND;
        end else if (timed_out) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESPOND;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (state_q == RESPOND) begin
      ack[grant_q] = 1'b1;
    end
    busy        = (state_q != IDLE);
    unit_start  = (state_q == ISSUE);
    unit_a      = a_q;
    unit_b      = b_q;
    resp_result = result_q;
    resp_err    = err_q;
  end

endmodule

// File: tb/tb_max_unit_scheduler.sv
// Directed bench for max_unit_scheduler with a behavioural max unit whose
// done drops one cycle after start and rises one cycle later.
module tb_max_unit_scheduler;

  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int TMO   = 20;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_a, req_b;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       resp_result;
  logic                   resp_err;
  logic                   busy;
  logic                   unit_start;
  logic [WIDTH-1:0]       unit_a, unit_b;
  logic [WIDTH-1:0]       unit_result;
  logic                   unit_done;

  logic [1:0]       u_stage;
  logic             u_done_q;
  logic [WIDTH-1:0] u_res_q, u_a, u_b;
  logic             u_dead;

  int n_chk  = 0;
  int n_fail = 0;
  int n_start = 0;

  always #5 clk = ~clk;

  max_unit_scheduler #(
    .N_REQ       (N_REQ),
    .WIDTH       (WIDTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_a       (req_a),
    .req_b       (req_b),
    .ack         (ack),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .busy        (busy),
    .unit_start  (unit_start),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .unit_result (unit_result),
    .unit_done   (unit_done)
  );

  // Behavioural max unit: stale done stays high for one cycle after start.
  always_ff @(posedge clk) begin
    if (reset) begin
      u_stage  <= 2'd0;
      u_done_q <= 1'b0;
      u_res_q  <= '0;
      u_a      <= '0;
      u_b      <= '0;
    end else if (unit_start) begin
      u_stage <= 2'd1;
      u_a     <= unit_a;
      u_b     <= unit_b;
    end else if (u_stage == 2'd1) begin
      u_done_q <= 1'b0;
      u_stage  <= 2'd2;
    end else if (u_stage == 2'd2) begin
      u_done_q <= 1'b1;
      u_res_q  <= (u_a > u_b) ? u_a : u_b;
      u_stage  <= 2'd0;
    end
  end

  assign unit_done   = u_dead ? 1'b0 : u_done_q;
  assign unit_result = u_res_q;

  always @(negedge clk) if (unit_start) n_start++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ops(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_start(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (unit_start) seen = 1'b1;
    end
    chk({tag, "_start_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_ack(input string tag, input int idx, input logic [31:0] res,
                          input logic err);
    bit seen;
    logic [N_REQ-1:0] exp_ack;
    exp_ack = 4'b0001 << idx;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (ack != '0) seen = 1'b1;
    end
    chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
      chk({tag, "_result"}, resp_result, res);
      chk({tag, "_err"}, 32'(resp_err), 32'(err));
      @(negedge clk);
      chk({tag, "_ack_pulse"}, 32'(ack), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    int n0;
    int lat;
    bit got;

    reset  = 1'b1;
    req    = '0;
    req_a  = '0;
    req_b  = '0;
    u_dead = 1'b0;
    step(3);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(unit_start), 32'd0);
    chk("rst_unit_a", unit_a, 32'd0);
    chk("rst_unit_b", unit_b, 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    reset = 1'b0;
    step(2);
    chk("idle_busy", 32'(busy), 32'd0);

    // Round-robin with all four requesting; unsigned max per pair.
    set_ops(0, 32'd10, 32'd20);
    set_ops(1, 32'd35, 32'd30);
    set_ops(2, 32'h8000_0000, 32'h7FFF_FFFF);
    set_ops(3, 32'd77, 32'd66);
    req = 4'b1111;
    wait_ack("rr0", 0, 32'd20, 1'b0);
    wait_ack("rr1", 1, 32'd35, 1'b0);
    wait_ack("rr2", 2, 32'h8000_0000, 1'b0);
    wait_ack("rr3", 3, 32'd77, 1'b0);
    wait_ack("rr4", 0, 32'd20, 1'b0);
    req = '0;
    step(2);

    // Single requester 0.
    n0 = n_start;
    set_ops(0, 32'd5, 32'd9);
    req = 4'b0001;
    wait_ack("single", 0, 32'd9, 1'b0);
    req = '0;
    chk("single_start_cnt", 32'(n_start - n0), 32'd1);
    step(2);

    // Back-to-back from requester 2; second must not see the stale done.
    set_ops(2, 32'hFFFF_FFFF, 32'd0);
    req = 4'b0100;
    wait_ack("b2b0", 2, 32'hFFFF_FFFF, 1'b0);
    set_ops(2, 32'd1, 32'd1);
    wait_ack("b2b1", 2, 32'd1, 1'b0);
    req = '0;
    step(2);

    // Requester 1 drops req and its operand changes mid-operation.
    set_ops(1, 32'd7, 32'd3);
    req = 4'b0010;
    wait_start("drop");
    set_ops(1, 32'd100, 32'd3);
    req = 4'b0000;
    @(negedge clk);
    chk("drop_unit_a_held", unit_a, 32'd7);
    wait_ack("drop", 1, 32'd7, 1'b0);
    step(2);

    // Timeout: unit never raises done.
    u_dead = 1'b1;
    set_ops(2, 32'd123, 32'd456);
    req = 4'b0100;
    wait_start("tmo");
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= TMO + 10 && !got; k++) begin
      @(negedge clk);
      if (ack != '0) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk("tmo_latency", 32'(lat), 32'(TMO + 1));
    chk("tmo_ack", 32'(ack), 32'b0100);
    chk("tmo_result", resp_result, 32'd0);
    chk("tmo_err", 32'(resp_err), 32'd1);
    req = '0;
    u_dead = 1'b0;
    step(2);

    // Reset while waiting on a dead unit: no ack, arbiter restarts at 0.
    u_dead = 1'b1;
    set_ops(1, 32'd5, 32'd6);
    req = 4'b0010;
    wait_start("rstmid");
    step(4);
    chk("rstmid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ack", 32'(ack), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    u_dead = 1'b0;
    step(3);
    chk("rstmid_no_ack", 32'(ack), 32'd0);
    set_ops(0, 32'd42, 32'd41);
    req = 4'b1111;
    wait_ack("rstmid_next", 0, 32'd42, 1'b0);
    req = '0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
